// File: rtl/riscv_soft_dmem.sv
// riscv_soft_dmem
// ---------------
// Soft data memory for a small RISC-V core. It accepts one load or store
// request at a time, waits a fixed number of access cycles, then issues a
// single-cycle response. The storage is a little-endian array of XPR_LEN-bit
// words addressed by byte address. The byte-lane logic assumes four bytes
// per word, so XPR_LEN is expected to stay at 32.
//
// Ports
//   clk                 : single clock, all state changes on its rising edge
//   reset               : asynchronous, active-low reset
//   d_cache_req_ready   : high when a new request can be accepted (IDLE only)
//   d_cache_req_valid   : request-present qualifier
//   d_cache_req_op      : 0 = load, 1 = store
//   d_cache_req_op_type : 000 byte, 001 half, 010 word,
//                         100 byte unsigned, 101 half unsigned
//   d_cache_req_addr    : byte address (upper bits beyond the array alias)
//   d_cache_req_data    : store data, right-aligned
//   d_cache_resp_valid  : one-cycle response strobe
//   d_cache_resp_data   : extended load data (0 for stores and errors)
//   d_cache_resp_error  : misaligned or illegal request, qualified by valid

module riscv_soft_dmem #(
  parameter int XPR_LEN     = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               d_cache_req_ready,
  input  logic               d_cache_req_valid,
  input  logic               d_cache_req_op,
  input  logic [2:0]         d_cache_req_op_type,
  input  logic [XPR_LEN-1:0] d_cache_req_addr,
  input  logic [XPR_LEN-1:0] d_cache_req_data,
  output logic               d_cache_resp_valid,
  output logic [XPR_LEN-1:0] d_cache_resp_data,
  output logic               d_cache_resp_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [3:0]         waitCnt_q, waitCnt_d;
  logic               ready_q, ready_d;
  logic               op_q;
  logic [2:0]         opType_q;
  logic [AW-1:0]      addr_q;
  logic [XPR_LEN-1:0] data_q;
  logic [XPR_LEN-1:0] respData_q, respData_d;
  logic               respErr_q, respErr_d;

  logic               accept;
  logic               commit;
  logic               curOp;
  logic [2:0]         curOpType;
  logic [AW-1:0]      curAddr;
  logic [XPR_LEN-1:0] curData;
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic               reqErr;
  logic [3:0]         byteEn;
  logic [XPR_LEN-1:0] wrData;
  logic [XPR_LEN-1:0] rdWord;
  logic [7:0]         rdByte;
  logic [15:0]        rdHalf;
  logic [XPR_LEN-1:0] loadVal;
  logic               unusedAddrHi;

  logic [XPR_LEN-1:0] mem [DEPTH];

  // Address bits above the array size are intentionally dropped so that
  // addresses alias modulo the array size.
  assign unusedAddrHi = ^d_cache_req_addr[XPR_LEN-1:AW];

  assign accept = d_cache_req_valid & ready_q;

  // With WAIT_CYCLES=0 the access completes on the accepting edge itself,
  // before the request registers hold anything, so the access datapath
  // reads the live inputs while IDLE and the captured copy otherwise.
  assign curOp     = (state_q == IDLE) ? d_cache_req_op      : op_q;
  assign curOpType = (state_q == IDLE) ? d_cache_req_op_type : opType_q;
  assign curAddr   = (state_q == IDLE) ? d_cache_req_addr[AW-1:0] : addr_q;
  assign curData   = (state_q == IDLE) ? d_cache_req_data    : data_q;
  assign wordIdx   = curAddr[AW-1:2];

  // The store commits and the load result is latched on the edge that
  // enters RESP, so a reset before that edge leaves memory untouched.
  assign commit = (state_q != RESP) && (state_d == RESP);

  // FSM next state and wait down-counter.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            waitCnt_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q <= 4'd1) begin
          state_d   = RESP;
          waitCnt_d = 4'd0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = 4'd0;
      end
    endcase
  end

  // Ready is registered so that it stays low throughout reset and rises on
  // the first edge after reset is released.
  assign ready_d = (state_d == IDLE);

  // Illegal codes, misalignment and unsigned stores all become error
  // responses with no write.
  always_comb begin
    reqErr = 1'b0;
    case (curOpType)
      OP_B, OP_BU: reqErr = 1'b0;
      OP_H, OP_HU: reqErr = curAddr[0];
      OP_W:        reqErr = (curAddr[1:0] != 2'b00);
      default:     reqErr = 1'b1;
    endcase
    if (curOp && curOpType[2]) begin
      reqErr = 1'b1;
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    byteEn = 4'b0000;
    wrData = curData;
    case (curOpType[1:0])
      2'b00: begin
        byteEn = 4'b0001 << curAddr[1:0];
        wrData = {4{curData[7:0]}};
      end
      2'b01: begin
        byteEn = curAddr[1] ? 4'b1100 : 4'b0011;
        wrData = {2{curData[15:0]}};
      end
      2'b10: begin
        byteEn = 4'b1111;
        wrData = curData;
      end
      default: begin
        byteEn = 4'b0000;
        wrData = curData;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  assign rdWord = mem[wordIdx];
  assign rdHalf = curAddr[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    rdByte = rdWord[7:0];
    case (curAddr[1:0])
      2'b00:   rdByte = rdWord[7:0];
      2'b01:   rdByte = rdWord[15:8];
      2'b10:   rdByte = rdWord[23:16];
      default: rdByte = rdWord[31:24];
    endcase
  end

  always_comb begin
    loadVal = '0;
    case (curOpType)
      OP_B:    loadVal = {{(XPR_LEN-8){rdByte[7]}}, rdByte};
      OP_H:    loadVal = {{(XPR_LEN-16){rdHalf[15]}}, rdHalf};
      OP_W:    loadVal = rdWord;
      OP_BU:   loadVal = {{(XPR_LEN-8){1'b0}}, rdByte};
      OP_HU:   loadVal = {{(XPR_LEN-16){1'b0}}, rdHalf};
      default: loadVal = '0;
    endcase
  end

  // Response data holds its last value outside RESP.
  always_comb begin
    respData_d = respData_q;
    respErr_d  = respErr_q;
    if (commit) begin
      respErr_d  = reqErr;
      respData_d = (reqErr || curOp) ? '0 : loadVal;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      ready_q    <= 1'b0;
      op_q       <= 1'b0;
      opType_q   <= 3'b000;
      addr_q     <= '0;
      data_q     <= '0;
      respData_q <= '0;
      respErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      ready_q    <= ready_d;
      respData_q <= respData_d;
      respErr_q  <= respErr_d;
      if (accept) begin
        op_q     <= d_cache_req_op;
        opType_q <= d_cache_req_op_type;
        addr_q   <= d_cache_req_addr[AW-1:0];
        data_q   <= d_cache_req_data;
      end
    end
  end

  // Memory array: never reset, written only by a legal committing store.
  always_ff @(posedge clk) begin
    if (commit && curOp && !reqErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  assign d_cache_req_ready  = ready_q;
  assign d_cache_resp_valid = (state_q == RESP);
  assign d_cache_resp_error = (state_q == RESP) & respErr_q;
  assign d_cache_resp_data  = respData_q;

endmodule

// File: doc/riscv_soft_dmem.md
RISCV_SOFT_DMEM -- requirements
Module: riscv_soft_dmem

Interface
REQ-001 The block SHALL have parameter XPR_LEN, default 32, the data and address width.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10, the log2 of the number of XPR_LEN-bit memory words.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, the extra access cycles before a response.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port d_cache_req_ready, output, 1 bit, asserted when a request can be accepted.
REQ-007 The block SHALL have port d_cache_req_valid, input, 1 bit, the request-present qualifier.
REQ-008 The block SHALL have port d_cache_req_op, input, 1 bit, where 0 is load and 1 is store.
REQ-009 The block SHALL have port d_cache_req_op_type, input, 3 bits, the size/sign code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-010 The block SHALL have port d_cache_req_addr, input, XPR_LEN bits, the byte address.
REQ-011 The block SHALL have port d_cache_req_data, input, XPR_LEN bits, the store data, right-aligned.
REQ-012 The block SHALL have port d_cache_resp_valid, output, 1 bit, a one-cycle response strobe.
REQ-013 The block SHALL have port d_cache_resp_data, output, XPR_LEN bits, the extended load data.
REQ-014 The block SHALL have port d_cache_resp_error, output, 1 bit, flagging a misaligned or illegal request; it is qualified by d_cache_resp_valid.

Function
REQ-015 The block SHALL accept a request on a rising edge only when d_cache_req_valid and d_cache_req_ready are both 1, and SHALL capture op, op_type, addr and data on that edge.
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 The FSM SHALL move IDLE->WAIT on acceptance when WAIT_CYCLES>0, and IDLE->RESP when WAIT_CYCLES=0.
REQ-018 The FSM SHALL remain in WAIT for exactly WAIT_CYCLES cycles, counted by a down-counter loaded on acceptance, and SHALL then move WAIT->RESP.
REQ-019 In RESP the block SHALL assert d_cache_resp_valid for exactly one cycle and SHALL then return unconditionally to IDLE; there is no response backpressure.
REQ-020 The block SHALL drive d_cache_req_ready=1 only in IDLE; at most one request is outstanding, so accepts are spaced at least WAIT_CYCLES+2 cycles apart.
REQ-021 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to the edge on which d_cache_resp_valid is first sampled 1.
REQ-022 Memory word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-023 Byte order SHALL be little-endian.
REQ-024 For a load, the selected byte or half SHALL be taken at addr[1:0]; codes 000/001 SHALL sign-extend and 100/101 SHALL zero-extend.
REQ-025 For a store, only the addressed bytes SHALL be written, using byte enables from op_type and addr[1:0]; d_cache_resp_data SHALL be 0 for a store.
REQ-026 A store write SHALL commit on the edge that enters RESP.
REQ-027 A load SHALL return memory contents that include every store whose response has completed before the load was accepted.
REQ-028 A half access with addr[0]=1, a word access with addr[1:0]!=0, any op_type outside REQ-009, or a store with op_type 100/101 SHALL produce a response with d_cache_resp_error=1 and d_cache_resp_data=0, and SHALL perform no write; it keeps the normal latency.
REQ-029 Outside RESP, d_cache_resp_valid and d_cache_resp_error SHALL be 0 and d_cache_resp_data SHALL hold its last value.
REQ-030 Request inputs SHALL be ignored while d_cache_req_ready=0.

Reset
REQ-031 While reset=0, the FSM SHALL be in IDLE, the counter SHALL be 0, and d_cache_req_ready, d_cache_resp_valid, d_cache_resp_error and d_cache_resp_data SHALL all be 0.
REQ-032 d_cache_req_ready SHALL rise on the first rising clk edge after reset deasserts.
REQ-033 Reset asserted mid-transaction SHALL abort it with no response; a store not yet committed SHALL perform no write.
REQ-034 Memory array contents SHALL NOT be reset.

Verification (WAIT_CYCLES=2)
REQ-035 Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_valid 3 cycles after each accept, and the load returns 0xDEADBEEF with error=0.
REQ-036 After REQ-035, load byte 0x13 -> returns 0xFFFFFFDE; load byte unsigned 0x13 -> returns 0x000000DE; load half 0x12 -> returns 0xFFFFDEAD.
REQ-037 Store byte 0x55 to 0x11, then load word 0x10 -> returns 0xDEAD55EF.
REQ-038 Load word from 0x12 -> error=1 and data=0; a following load word from 0x10 shows the word unchanged.
REQ-039 Hold valid=1 continuously -> ready is low for cycles 1-3 after each accept, and exactly one resp_valid pulse occurs per accept.
REQ-040 Assert reset one cycle after accepting a store of 0x12345678 to 0x20 -> no resp_valid; after reset, a load word from 0x20 returns the prior value.
